// File: rtl/hpsdr_stream_pkg.sv
// Shared constants and types for the HPSDR stream blocks.
package hpsdr_stream_pkg;

   localparam int DEFAULT_IN_WIDTH  = 32;
   localparam int DEFAULT_OUT_WIDTH = 16;
   localparam int OVF_COUNT_WIDTH   = 16;

   // Number of narrow sub-words that make up one wide word.
   function automatic int calc_ratio(input int in_width, input int out_width);
      return in_width / out_width;
   endfunction

   localparam int DEFAULT_RATIO = calc_ratio(DEFAULT_IN_WIDTH, DEFAULT_OUT_WIDTH);

   typedef enum logic {
      IDLE,
      ACTIVE
   } out_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Storage array; no reset needed since reads are gated by the pointers.
   always_ff @(posedge aclk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Read and write pointers; the extra MSB distinguishes full from empty.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_word_unpacker.sv
// Buffers wide words from a non-stallable source and emits them as narrow
// AXI4-Stream sub-words, with tlast on the final sub-word of each word.
// Optional macro UNPACK_OVF_COUNT_EN adds a saturating dropped-word counter.
// IN_WIDTH is expected to equal RATIO*OUT_WIDTH.
module axis_word_unpacker
   import hpsdr_stream_pkg::*;
#(
   parameter int IN_WIDTH   = DEFAULT_IN_WIDTH,
   parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
   parameter int RATIO      = DEFAULT_RATIO,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_FIRST  = 1
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [IN_WIDTH-1:0]             s_axis_tdata,
   input  logic                            s_axis_tvalid,
   output logic [OUT_WIDTH-1:0]            m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            overflow,
`ifdef UNPACK_OVF_COUNT_EN
   output logic [OVF_COUNT_WIDTH-1:0]      ovf_count,
`endif
   input  logic                            clear_overflow
);

   localparam int IDX_W = $clog2(RATIO);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   out_state_t          state;
   out_state_t          state_nxt;
   logic [IN_WIDTH-1:0] word_reg;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    sel;
   logic [IN_WIDTH-1:0] fifo_rdata;
   logic                fifo_full;
   logic                fifo_empty;
   logic                handshake;
   logic                last_sub;
   logic                pop;
   logic                drop;

   assign handshake = (state == ACTIVE) && m_axis_tready;
   assign last_sub  = (idx == LAST_IDX);
   assign pop       = !fifo_empty && ((state == IDLE) || (handshake && last_sub));
   assign drop      = s_axis_tvalid && fifo_full && !pop;

   sync_word_fifo #(
      .WIDTH (IN_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (s_axis_tvalid),
      .wdata   (s_axis_tdata),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Output state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: go active on a pop, go idle only after the last sub-word with nothing queued.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = ACTIVE;
         ACTIVE:  if (handshake && last_sub && fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Current word and sub-word index; a back-to-back pop restarts at index 0 without a bubble.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         word_reg <= '0;
         idx      <= '0;
      end else if (pop) begin
         word_reg <= fifo_rdata;
         idx      <= '0;
      end else if (handshake) begin
         idx <= last_sub ? '0 : idx + 1'b1;
      end
   end

   // Stream outputs decoded from registered state only, so no input-to-output path exists.
   always_comb begin
      sel           = (LOW_FIRST != 0) ? idx : (LAST_IDX - idx);
      m_axis_tvalid = (state == ACTIVE);
      m_axis_tlast  = (state == ACTIVE) && last_sub;
      m_axis_tdata  = word_reg[int'(sel) * OUT_WIDTH +: OUT_WIDTH];
   end

   // Sticky overflow flag; a new drop wins over a clear in the same cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clear_overflow) begin
         overflow <= 1'b0;
      end
   end

`ifdef UNPACK_OVF_COUNT_EN
   // Saturating count of dropped words; a drop coinciding with a clear restarts the count at 1.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ovf_count <= '0;
      end else if (clear_overflow) begin
         ovf_count <= drop ? OVF_COUNT_WIDTH'(1) : '0;
      end else if (drop && (ovf_count != '1)) begin
         ovf_count <= ovf_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_word_unpacker.sv
// Directed self-checking bench for axis_word_unpacker (LSB-first and MSB-first instances).
module tb_axis_word_unpacker;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s2_axis_tvalid;
   logic        m_axis_tready;
   logic        m2_axis_tready;
   logic        clear_overflow;

   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic [4:0]  fifo_count;
   logic        overflow;

   logic [15:0] m2_axis_tdata;
   logic        m2_axis_tvalid;
   logic        m2_axis_tlast;
   logic [4:0]  m2_fifo_count;
   logic        m2_overflow;

`ifdef UNPACK_OVF_COUNT_EN
   logic [15:0] ovf_count;
   logic [15:0] m2_ovf_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] t3_words [4];
   logic [15:0] t3_exp   [8];

   axis_word_unpacker #(
      .IN_WIDTH   (32),
      .OUT_WIDTH  (16),
      .RATIO      (2),
      .FIFO_DEPTH (16),
      .LOW_FIRST  (1)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
`ifdef UNPACK_OVF_COUNT_EN
      .ovf_count      (ovf_count),
`endif
      .clear_overflow (clear_overflow)
   );

   axis_word_unpacker #(
      .IN_WIDTH   (32),
      .OUT_WIDTH  (16),
      .RATIO      (2),
      .FIFO_DEPTH (16),
      .LOW_FIRST  (0)
   ) dut_msb (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s2_axis_tvalid),
      .m_axis_tdata   (m2_axis_tdata),
      .m_axis_tvalid  (m2_axis_tvalid),
      .m_axis_tready  (m2_axis_tready),
      .m_axis_tlast   (m2_axis_tlast),
      .fifo_count     (m2_fifo_count),
      .overflow       (m2_overflow),
`ifdef UNPACK_OVF_COUNT_EN
      .ovf_count      (m2_ovf_count),
`endif
      .clear_overflow (clear_overflow)
   );

   // 100 MHz-style free-running clock.
   always #5 aclk = ~aclk;

   // Hard time limit so the run always ends even if something wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkStream(input string tag, input logic valid, input logic [15:0] data, input logic last);
      checkOutput({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, {31'd0, valid});
      checkOutput({tag, "_tdata"},  {16'd0, m_axis_tdata},  {16'd0, data});
      checkOutput({tag, "_tlast"},  {31'd0, m_axis_tlast},  {31'd0, last});
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] data);
      s_axis_tvalid = valid;
      s_axis_tdata  = data;
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      t3_words = '{32'hA0A1B0B1, 32'hC0C1D0D1, 32'hE0E1F0F1, 32'h01020304};
      t3_exp   = '{16'hB0B1, 16'hA0A1, 16'hD0D1, 16'hC0C1,
                   16'hF0F1, 16'hE0E1, 16'h0304, 16'h0102};

      aresetn        = 1'b0;
      s_axis_tdata   = '0;
      s_axis_tvalid  = 1'b0;
      s2_axis_tvalid = 1'b0;
      m_axis_tready  = 1'b0;
      m2_axis_tready = 1'b1;
      clear_overflow = 1'b0;

      // Reset state.
      #22;
      checkStream("rst", 1'b0, 16'h0000, 1'b0);
      checkOutput("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
      checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      tick();

      // Single word, LSB first: strobe launched now, written next edge, popped the edge after.
      $display("[TB] single word LSB first");
      m_axis_tready = 1'b1;
      applyStimulus(1'b1, 32'h12345678);
      tick();
      applyStimulus(1'b0, 32'h0);
      checkOutput("t1_pre_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      checkOutput("t1_fifo_count", {27'd0, fifo_count}, 32'd1);
      tick();
      checkStream("t1_sub0", 1'b1, 16'h5678, 1'b0);
      tick();
      checkStream("t1_sub1", 1'b1, 16'h1234, 1'b1);
      tick();
      checkOutput("t1_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      checkOutput("t1_idle_count", {27'd0, fifo_count}, 32'd0);

      // Same word on the MSB-first instance.
      $display("[TB] single word MSB first");
      s_axis_tdata   = 32'h12345678;
      s2_axis_tvalid = 1'b1;
      tick();
      s2_axis_tvalid = 1'b0;
      tick();
      checkOutput("t2_sub0_tvalid", {31'd0, m2_axis_tvalid}, 32'd1);
      checkOutput("t2_sub0_tdata", {16'd0, m2_axis_tdata}, 32'h1234);
      checkOutput("t2_sub0_tlast", {31'd0, m2_axis_tlast}, 32'd0);
      tick();
      checkOutput("t2_sub1_tvalid", {31'd0, m2_axis_tvalid}, 32'd1);
      checkOutput("t2_sub1_tdata", {16'd0, m2_axis_tdata}, 32'h5678);
      checkOutput("t2_sub1_tlast", {31'd0, m2_axis_tlast}, 32'd1);
      tick();
      checkOutput("t2_idle_tvalid", {31'd0, m2_axis_tvalid}, 32'd0);

      // Four words every second cycle: eight contiguous sub-words after edge 2 through edge 9.
      $display("[TB] streaming every second cycle");
      for (int c = 0; c < 12; c++) begin
         if ((c % 2 == 0) && (c / 2 < 4)) begin
            applyStimulus(1'b1, t3_words[c / 2]);
         end else begin
            applyStimulus(1'b0, 32'h0);
         end
         tick();
         if ((c + 1 >= 2) && (c + 1 <= 9)) begin
            checkStream("t3_sub", 1'b1, t3_exp[c - 1], ((c - 1) % 2) == 1);
         end else if (c + 1 >= 10) begin
            checkOutput("t3_tail_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
         end
      end
      checkOutput("t3_overflow", {31'd0, overflow}, 32'd0);

      // Stalled sink, 18 back-to-back strobes: word 1 in register, 2..17 queued, 18 dropped.
      $display("[TB] overflow with stalled sink");
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         applyStimulus(1'b1, {16'(16'h1000 + i), 16'(16'h2000 + i)});
         tick();
      end
      applyStimulus(1'b0, 32'h0);
      checkOutput("t4_fifo_count", {27'd0, fifo_count}, 32'd16);
      checkOutput("t4_overflow", {31'd0, overflow}, 32'd1);
      checkStream("t4_head", 1'b1, 16'h2001, 1'b0);
`ifdef UNPACK_OVF_COUNT_EN
      checkOutput("t4_ovf_count", {16'd0, ovf_count}, 32'd1);
`endif
      m_axis_tready = 1'b1;
      for (int j = 0; j < 34; j++) begin
         if (j % 2 == 0) begin
            checkStream("t4_drain", 1'b1, 16'(16'h2000 + j / 2 + 1), 1'b0);
         end else begin
            checkStream("t4_drain", 1'b1, 16'(16'h1000 + j / 2 + 1), 1'b1);
         end
         tick();
      end
      checkOutput("t4_done_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      checkOutput("t4_done_count", {27'd0, fifo_count}, 32'd0);
      checkOutput("t4_still_sticky", {31'd0, overflow}, 32'd1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      checkOutput("t4_cleared", {31'd0, overflow}, 32'd0);
`ifdef UNPACK_OVF_COUNT_EN
      checkOutput("t4_ovf_cleared", {16'd0, ovf_count}, 32'd0);
`endif

      // Backpressure mid-word: tready 1,0,0,1 with data held while low.
      $display("[TB] backpressure mid-word");
      m_axis_tready = 1'b0;
      applyStimulus(1'b1, 32'hCAFEBABE);
      tick();
      applyStimulus(1'b0, 32'h0);
      tick();
      checkStream("t5_sub0", 1'b1, 16'hBABE, 1'b0);
      m_axis_tready = 1'b1;
      tick();
      checkStream("t5_sub1", 1'b1, 16'hCAFE, 1'b1);
      m_axis_tready = 1'b0;
      tick();
      checkStream("t5_hold1", 1'b1, 16'hCAFE, 1'b1);
      tick();
      checkStream("t5_hold2", 1'b1, 16'hCAFE, 1'b1);
      m_axis_tready = 1'b1;
      tick();
      checkOutput("t5_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

      // Asynchronous reset between sub-words with three words queued.
      $display("[TB] reset mid-word");
      m_axis_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, {16'(16'h3000 + i), 16'(16'h4000 + i)});
         tick();
      end
      applyStimulus(1'b0, 32'h0);
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      checkStream("t6_pre_sub1", 1'b1, 16'h3000, 1'b1);
      checkOutput("t6_pre_count", {27'd0, fifo_count}, 32'd3);
      #2;
      aresetn = 1'b0;
      #1;
      checkStream("t6_in_reset", 1'b0, 16'h0000, 1'b0);
      checkOutput("t6_reset_count", {27'd0, fifo_count}, 32'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      applyStimulus(1'b1, 32'h55667788);
      tick();
      applyStimulus(1'b0, 32'h0);
      tick();
      checkStream("t6_new_sub0", 1'b1, 16'h7788, 1'b0);
      tick();
      checkStream("t6_new_sub1", 1'b1, 16'h5566, 1'b1);
      tick();
      checkOutput("t6_new_idle", {31'd0, m_axis_tvalid}, 32'd0);

      // Drop coinciding with clear_overflow: set wins.
      $display("[TB] clear versus drop");
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         applyStimulus(1'b1, 32'(i));
         tick();
      end
      applyStimulus(1'b0, 32'h0);
      checkOutput("t7_overflow_set", {31'd0, overflow}, 32'd1);
      clear_overflow = 1'b1;
      tick();
      checkOutput("t7_overflow_clear", {31'd0, overflow}, 32'd0);
`ifdef UNPACK_OVF_COUNT_EN
      checkOutput("t7_ovf_count_clear", {16'd0, ovf_count}, 32'd0);
`endif
      applyStimulus(1'b1, 32'hDEADBEEF);
      tick();
      applyStimulus(1'b0, 32'h0);
      clear_overflow = 1'b0;
      checkOutput("t7_set_wins", {31'd0, overflow}, 32'd1);
      checkOutput("t7_full_count", {27'd0, fifo_count}, 32'd16);
`ifdef UNPACK_OVF_COUNT_EN
      checkOutput("t7_ovf_count_one", {16'd0, ovf_count}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
